// File: rtl/average_power_detector.sv
// ---------------------------------------------------------------------------
// Module  : average_power_detector
// Brief   : Mean |x|^2 over non-overlapping windows of 2^AVG_WINDOW_BITS samples.
//           Optional macro AVG_POWER_ROUND_EN selects round-half-up over floor.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module average_power_detector #(
  parameter int DATA_WIDTH      = 32,
  parameter int AVG_WINDOW_BITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid_in,
  output logic [DATA_WIDTH-1:0] avg_power_out,
  output logic                  avg_power_valid
);

  localparam int HW    = DATA_WIDTH / 2;
  localparam int ACC_W = DATA_WIDTH + AVG_WINDOW_BITS;
  localparam logic [AVG_WINDOW_BITS-1:0] C_CNT_LAST = '1;
  localparam logic [AVG_WINDOW_BITS-1:0] C_CNT_ONE  = AVG_WINDOW_BITS'(1);

  // I and Q sign-extended to full width so each square is a DATA_WIDTH product
  logic signed [DATA_WIDTH-1:0] w_i_ext;
  logic signed [DATA_WIDTH-1:0] w_q_ext;
  logic signed [DATA_WIDTH-1:0] w_ii;
  logic signed [DATA_WIDTH-1:0] w_qq;

  assign w_i_ext = $signed({{HW{sample_in[DATA_WIDTH-1]}}, sample_in[DATA_WIDTH-1:HW]});
  assign w_q_ext = $signed({{HW{sample_in[HW-1]}}, sample_in[HW-1:0]});
  assign w_ii    = w_i_ext * w_i_ext;
  assign w_qq    = w_q_ext * w_q_ext;

  logic [DATA_WIDTH-1:0]      sq_i_q, sq_q_q, p_q, res_q;
  logic                       v1_q, v2_q, done_q;
  logic [ACC_W-1:0]           acc_q;
  logic [AVG_WINDOW_BITS-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      sq_i_q <= '0;
      sq_q_q <= '0;
      p_q    <= '0;
    end else begin
      v1_q <= sample_valid_in;
      v2_q <= v1_q;
      if (sample_valid_in) begin
        sq_i_q <= w_ii;
        sq_q_q <= w_qq;
      end
      if (v1_q) begin
        p_q <= sq_i_q + sq_q_q;
      end
    end
  end

  logic [ACC_W-1:0]           w_acc_sum;
  logic [DATA_WIDTH-1:0]      w_result;
  logic [ACC_W-1:0]           acc_d;
  logic [AVG_WINDOW_BITS-1:0] cnt_d;
  logic                       done_d;
  logic [DATA_WIDTH-1:0]      res_d;

  assign w_acc_sum = acc_q + {{AVG_WINDOW_BITS{1'b0}}, p_q};

`ifdef AVG_POWER_ROUND_EN
  localparam logic [ACC_W:0] C_HALF = {{ACC_W{1'b0}}, 1'b1} << (AVG_WINDOW_BITS - 1);
  logic [ACC_W:0] w_rounded;
  logic [ACC_W:0] w_shifted;

  assign w_rounded = {1'b0, w_acc_sum} + C_HALF;
  assign w_shifted = w_rounded >> AVG_WINDOW_BITS;
  assign w_result  = (|w_shifted[ACC_W:DATA_WIDTH]) ? {DATA_WIDTH{1'b1}}
                                                    : w_shifted[DATA_WIDTH-1:0];
`else
  assign w_result = w_acc_sum[ACC_W-1:AVG_WINDOW_BITS];
`endif

  // The window-closing sample is folded in via w_acc_sum, never written to acc
  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    res_d  = res_q;
    if (v2_q) begin
      if (cnt_q == C_CNT_LAST) begin
        acc_d  = '0;
        cnt_d  = '0;
        done_d = 1'b1;
        res_d  = w_result;
      end else begin
        acc_d = w_acc_sum;
        cnt_d = cnt_q + C_CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q           <= '0;
      cnt_q           <= '0;
      done_q          <= 1'b0;
      res_q           <= '0;
      avg_power_out   <= '0;
      avg_power_valid <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
      res_q  <= res_d;
      if (done_q) begin
        avg_power_out   <= res_q;
        avg_power_valid <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_average_power_detector.sv
// ---------------------------------------------------------------------------
// Module  : tb_average_power_detector
// Brief   : Directed self-checking bench for average_power_detector.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_average_power_detector;

  logic        clk;
  logic        rst;
  logic [31:0] sample_in;
  logic        sample_valid_in;
  logic [31:0] avg_power_out;
  logic        avg_power_valid;

  int n_tests;
  int n_fail;

`ifdef AVG_POWER_ROUND_EN
  localparam logic [31:0] EXP_RAMP = 32'h0000_54D6;
`else
  localparam logic [31:0] EXP_RAMP = 32'h0000_54D5;
`endif

  average_power_detector #(
    .DATA_WIDTH     (32),
    .AVG_WINDOW_BITS(10)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .sample_in      (sample_in),
    .sample_valid_in(sample_valid_in),
    .avg_power_out  (avg_power_out),
    .avg_power_valid(avg_power_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input int i_val, input int q_val);
    return {i_val[15:0], q_val[15:0]};
  endfunction

  // Sends 1024 valid samples; returns at the negedge right after the last accepting edge
  task automatic send_window(input int i_val, input int q_val, input bit gap);
    for (int k = 0; k < 1024; k++) begin
      if (gap) begin
        @(negedge clk);
        sample_valid_in = 1'b0;
      end
      @(negedge clk);
      sample_in       = pack(i_val, q_val);
      sample_valid_in = 1'b1;
    end
    @(negedge clk);
    sample_valid_in = 1'b0;
  endtask

  // Result must still be the old value after 2 edges and the new one after the 3rd
  task automatic check_latency(input string tag, input logic [31:0] old_v,
                               input logic old_valid, input logic [31:0] new_v);
    repeat (2) @(negedge clk);
    check({tag, "_hold"}, avg_power_out, old_v);
    check({tag, "_hold_vld"}, 32'(avg_power_valid), 32'(old_valid));
    @(negedge clk);
    check({tag, "_out"}, avg_power_out, new_v);
    check({tag, "_vld"}, 32'(avg_power_valid), 32'd1);
  endtask

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    rst             = 1'b1;
    sample_in       = '0;
    sample_valid_in = 1'b0;

    // Reset held with random inputs
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k > 0) begin
        check("rst_out", avg_power_out, 32'd0);
        check("rst_vld", 32'(avg_power_valid), 32'd0);
      end
      sample_in       = $urandom;
      sample_valid_in = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    rst             = 1'b0;
    sample_valid_in = 1'b0;
    check("rst_rel_out", avg_power_out, 32'd0);
    check("rst_rel_vld", 32'(avg_power_valid), 32'd0);

    // Ramp Q = 0..255, two gapless windows
    for (int k = 0; k < 2048; k++) begin
      @(negedge clk);
      if (k == 1026) begin
        check("ramp_w1_pre_vld", 32'(avg_power_valid), 32'd0);
        check("ramp_w1_pre_out", avg_power_out, 32'd0);
      end
      if (k == 1027) begin
        check("ramp_w1_vld", 32'(avg_power_valid), 32'd1);
        check("ramp_w1_out", avg_power_out, EXP_RAMP);
      end
      sample_in       = pack(0, k % 256);
      sample_valid_in = 1'b1;
    end
    @(negedge clk);
    sample_valid_in = 1'b0;
    repeat (3) @(negedge clk);
    check("ramp_w2_out", avg_power_out, EXP_RAMP);
    repeat (100) @(negedge clk);
    check("ramp_idle_out", avg_power_out, EXP_RAMP);
    check("ramp_idle_vld", 32'(avg_power_valid), 32'd1);

    // Constant windows: 3+4j, full-scale negative, then 3+4j with gaps
    send_window(3, 4, 1'b0);
    check_latency("c34", EXP_RAMP, 1'b1, 32'h0000_0019);
    send_window(-32768, -32768, 1'b0);
    check_latency("fullscale", 32'h0000_0019, 1'b1, 32'h8000_0000);
    send_window(3, 4, 1'b1);
    check_latency("c34_gap", 32'h8000_0000, 1'b1, 32'h0000_0019);

    // Reset mid-window discards 500 accumulated samples
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      sample_in       = pack(100, 0);
      sample_valid_in = 1'b1;
    end
    @(negedge clk);
    sample_valid_in = 1'b0;
    rst             = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out", avg_power_out, 32'd0);
    check("midrst_vld", 32'(avg_power_valid), 32'd0);
    send_window(1, 0, 1'b0);
    check_latency("after_rst", 32'd0, 1'b0, 32'h0000_0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
